cp0_regfile: RTL and testbench
==============================

CP0_REGFILE -- requirements
Module: cp0_regfile

Interface
REQ-001 parameter COUNT_DIV, default 2, meaning Count increments once per COUNT_DIV clk cycles (legal values 1 or 2).
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 rd_addr  input  5  CP0 register number read by MFC0 (sel fixed 0).
REQ-005 rd_data  output  32  combinational read data for rd_addr.
REQ-006 wr_en  input  1  MTC0 write strobe.
REQ-007 wr_addr  input  5  MTC0 destination register number.
REQ-008 wr_data  input  32  MTC0 write data.
REQ-009 exc_valid  input  1  exception commit this cycle.
REQ-010 exc_code  input  5  Cause.ExcCode value for the exception.
REQ-011 exc_pc  input  32  PC of the faulting instruction.
REQ-012 exc_bd  input  1  faulting instruction sits in a branch delay slot.
REQ-013 exc_badvaddr_we  input  1  exception carries a bad virtual address.
REQ-014 exc_badvaddr  input  32  bad virtual address value.
REQ-015 eret  input  1  ERET commit this cycle.
REQ-016 hw_int  input  6  external interrupt lines, level-sensitive.
REQ-017 epc_out  output  32  current EPC, used as the ERET target.
REQ-018 status_out  output  32  current Status.
REQ-019 cause_out  output  32  current Cause.
REQ-020 int_req  output  1  interrupt pending and enabled.

Function
REQ-021 Implemented registers: BadVAddr=8, Count=9, Compare=11, Status=12, Cause=13, EPC=14; rd_data SHALL be 0 for any other rd_addr.
REQ-022 rd_data SHALL return the pre-edge register value; a same-cycle MTC0 to the same address SHALL be visible only from the next cycle.
REQ-023 Status writable bits: IM[15:8], EXL[1], IE[0]; BEV[22] SHALL be read-only 1; all other bits SHALL read 0.
REQ-024 Cause writable bits: IP[9:8] only; BD[31], TI[30], IP[15:10] and ExcCode[6:2] SHALL be hardware-written only.
REQ-025 Cause.IP[15:10] SHALL register hw_int every cycle; Cause.IP[15] SHALL be hw_int[5] OR TI.
REQ-026 Count SHALL increment by 1 every COUNT_DIV cycles through an internal tick toggle, and SHALL wrap from 0xFFFF_FFFF to 0.
REQ-027 An MTC0 write to Count SHALL load wr_data and reset the tick phase; that cycle SHALL NOT also increment Count.
REQ-028 TI SHALL set on the cycle after Count equals Compare; it SHALL remain set until an MTC0 write to Compare, which clears it.
REQ-029 On exc_valid: Status.EXL SHALL be set to 1 and Cause.ExcCode SHALL be set to exc_code; if EXL was 0, EPC SHALL become exc_bd ? exc_pc-4 : exc_pc and Cause.BD SHALL become exc_bd; if EXL was 1, EPC and BD SHALL be left unchanged.
REQ-030 BadVAddr SHALL load exc_badvaddr only when exc_valid and exc_badvaddr_we are both 1.
REQ-031 On eret without exc_valid, Status.EXL SHALL clear to 0.
REQ-032 Same-cycle priority: exc_valid over eret over wr_en; a lower-priority event SHALL be dropped only for the fields the higher one writes. An MTC0 to Count or Compare SHALL still complete when eret fires in the same cycle.
REQ-033 int_req = Status.IE AND NOT Status.EXL AND |(Cause.IP[15:8] AND Status.IM[15:8]), taken from registered values.
REQ-034 status_out, cause_out and epc_out SHALL equal the register contents, updated one cycle after the event that writes them.

Reset
REQ-035 While rst_n=0, independent of clk: Status=0x0040_0000, Cause=0, Count=0, Compare=0, EPC=0, BadVAddr=0, tick phase=0, int_req=0.
REQ-036 Reset asserted mid-operation SHALL drop any pending TI and any in-flight write.

Verification
REQ-037 Reset, then read addr 12 -> rd_data=0x0040_0000; read addr 5 -> 0.
REQ-038 MTC0 Compare=5 with COUNT_DIV=2 -> TI=1 once Count reaches 5; with Status=0x0000_8001 -> int_req=1; MTC0 Compare again -> TI=0 on the next cycle.
REQ-039 exc_valid with code 4, pc 0xBFC0_0100, bd=1, badvaddr 0x1003 -> EPC=0xBFC0_00FC, BD=1, ExcCode=4, EXL=1, BadVAddr=0x1003; a second exception while EXL=1 -> EPC unchanged.
REQ-040 exc_valid and eret in the same cycle -> EXL=1; eret alone on the next cycle -> EXL=0.
REQ-041 MTC0 Count=0xFFFF_FFFF -> Count reads 0 after the next tick; MTC0 Cause=0xFFFF_FFFF -> cause_out shows only bits 9:8 set, plus any live hw_int/TI bits.
REQ-042 hw_int[2]=1 with Status=0x0000_1001 -> int_req=1 two cycles later; set EXL by exception -> int_req=0.

Source files
------------

// File: rtl/cp0_if.sv
// rtl/cp0_if.sv - CP0 register file bus: MFC0/MTC0 access, exception/ERET commit, status outputs
interface cp0_if;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        exc_valid;
    logic [4:0]  exc_code;
    logic [31:0] exc_pc;
    logic        exc_bd;
    logic        exc_badvaddr_we;
    logic [31:0] exc_badvaddr;
    logic        eret;
    logic [5:0]  hw_int;
    logic [31:0] epc_out;
    logic [31:0] status_out;
    logic [31:0] cause_out;
    logic        int_req;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data,
        output exc_valid, exc_code, exc_pc, exc_bd, exc_badvaddr_we, exc_badvaddr,
        output eret, hw_int,
        input  rd_data, epc_out, status_out, cause_out, int_req
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data,
        input  exc_valid, exc_code, exc_pc, exc_bd, exc_badvaddr_we, exc_badvaddr,
        input  eret, hw_int,
        output rd_data, epc_out, status_out, cause_out, int_req
    );
endinterface

// File: rtl/cp0_regfile.sv
// rtl/cp0_regfile.sv - MIPS CP0 subset: BadVAddr, Count, Compare, Status, Cause, EPC
module cp0_regfile #(
    parameter int COUNT_DIV = 2
) (
    input  logic  clk,
    input  logic  rst_n,
    cp0_if.slave  bus
);
    localparam logic [4:0] A_BADVADDR = 5'd8;
    localparam logic [4:0] A_COUNT    = 5'd9;
    localparam logic [4:0] A_COMPARE  = 5'd11;
    localparam logic [4:0] A_STATUS   = 5'd12;
    localparam logic [4:0] A_CAUSE    = 5'd13;
    localparam logic [4:0] A_EPC      = 5'd14;

    logic [7:0]  im_q, im_d;
    logic        exl_q, exl_d;
    logic        ie_q, ie_d;
    logic        bd_q, bd_d;
    logic        ti_q, ti_d;
    logic [5:0]  ip_hw_q, ip_hw_d;
    logic [1:0]  ip_sw_q, ip_sw_d;
    logic [4:0]  exc_code_q, exc_code_d;
    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] badvaddr_q, badvaddr_d;
    logic        tick_q, tick_d;
    logic        int_req_q, int_req_d;

    logic [31:0] status_val;
    logic [31:0] cause_val;
    logic [7:0]  cause_ip;
    logic        wr_count;
    logic        wr_compare;

    // Timer interrupt shares IP7 with hw_int[5]
    assign cause_ip   = {ip_hw_q[5] | ti_q, ip_hw_q[4:0], ip_sw_q};
    assign status_val = {9'b0, 1'b1, 6'b0, im_q, 6'b0, exl_q, ie_q};
    assign cause_val  = {bd_q, ti_q, 14'b0, cause_ip, 1'b0, exc_code_q, 2'b0};

    assign wr_count   = bus.wr_en && (bus.wr_addr == A_COUNT);
    assign wr_compare = bus.wr_en && (bus.wr_addr == A_COMPARE);

    always_comb begin
        im_d       = im_q;
        exl_d      = exl_q;
        ie_d       = ie_q;
        bd_d       = bd_q;
        ip_sw_d    = ip_sw_q;
        exc_code_d = exc_code_q;
        compare_d  = compare_q;
        epc_d      = epc_q;
        badvaddr_d = badvaddr_q;
        count_d    = count_q;
        tick_d     = tick_q;
        ip_hw_d    = bus.hw_int;

        // Lowest priority first; later events override only the fields they own
        if (bus.wr_en) begin
            case (bus.wr_addr)
                A_COMPARE: compare_d = bus.wr_data;
                A_STATUS: begin
                    im_d  = bus.wr_data[15:8];
                    exl_d = bus.wr_data[1];
                    ie_d  = bus.wr_data[0];
                end
                A_CAUSE:  ip_sw_d = bus.wr_data[9:8];
                A_EPC:    epc_d   = bus.wr_data;
                default: ;
            endcase
        end

        if (bus.eret && !bus.exc_valid) begin
            exl_d = 1'b0;
        end

        if (bus.exc_valid) begin
            exl_d      = 1'b1;
            exc_code_d = bus.exc_code;
            if (!exl_q) begin
                epc_d = bus.exc_bd ? (bus.exc_pc - 32'd4) : bus.exc_pc;
                bd_d  = bus.exc_bd;
            end
            if (bus.exc_badvaddr_we) begin
                badvaddr_d = bus.exc_badvaddr;
            end
        end

        if (wr_count) begin
            count_d = bus.wr_data;
            tick_d  = 1'b0;
        end else if (COUNT_DIV == 1) begin
            count_d = count_q + 32'd1;
        end else begin
            tick_d = ~tick_q;
            if (tick_q) begin
                count_d = count_q + 32'd1;
            end
        end

        ti_d      = wr_compare ? 1'b0 : (ti_q | (count_q == compare_q));
        int_req_d = ie_q & ~exl_q & (|(cause_ip & im_q));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            im_q       <= 8'h0;
            exl_q      <= 1'b0;
            ie_q       <= 1'b0;
            bd_q       <= 1'b0;
            ti_q       <= 1'b0;
            ip_hw_q    <= 6'h0;
            ip_sw_q    <= 2'h0;
            exc_code_q <= 5'h0;
            count_q    <= 32'h0;
            compare_q  <= 32'h0;
            epc_q      <= 32'h0;
            badvaddr_q <= 32'h0;
            tick_q     <= 1'b0;
            int_req_q  <= 1'b0;
        end else begin
            im_q       <= im_d;
            exl_q      <= exl_d;
            ie_q       <= ie_d;
            bd_q       <= bd_d;
            ti_q       <= ti_d;
            ip_hw_q    <= ip_hw_d;
            ip_sw_q    <= ip_sw_d;
            exc_code_q <= exc_code_d;
            count_q    <= count_d;
            compare_q  <= compare_d;
            epc_q      <= epc_d;
            badvaddr_q <= badvaddr_d;
            tick_q     <= tick_d;
            int_req_q  <= int_req_d;
        end
    end

    always_comb begin
        case (bus.rd_addr)
            A_BADVADDR: bus.rd_data = badvaddr_q;
            A_COUNT:    bus.rd_data = count_q;
            A_COMPARE:  bus.rd_data = compare_q;
            A_STATUS:   bus.rd_data = status_val;
            A_CAUSE:    bus.rd_data = cause_val;
            A_EPC:      bus.rd_data = epc_q;
            default:    bus.rd_data = 32'h0;
        endcase
    end

    assign bus.status_out = status_val;
    assign bus.cause_out  = cause_val;
    assign bus.epc_out    = epc_q;
    assign bus.int_req    = int_req_q;
endmodule

// File: tb/tb_cp0_regfile.sv
// tb/tb_cp0_regfile.sv - scoreboard bench for cp0_regfile against a word-level reference model
module tb_cp0_regfile;
    localparam int DIV = 2;

    logic clk;
    logic rst_n;
    cp0_if bus ();

    cp0_regfile #(.COUNT_DIV(DIV)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          rst;
        logic [4:0]  rd_addr;
        bit          wr_en;
        logic [4:0]  wr_addr;
        logic [31:0] wr_data;
        bit          exc;
        logic [4:0]  code;
        logic [31:0] pc;
        bit          bd;
        bit          bwe;
        logic [31:0] bva;
        bit          eret;
        logic [5:0]  hw;
    } stim_t;

    typedef struct {
        logic [31:0] rd;
        logic [31:0] st;
        logic [31:0] ca;
        logic [31:0] epc;
        logic        ir;
    } exp_t;

    exp_t expq[$];
    int n_chk  = 0;
    int n_pass = 0;
    logic [5:0] cur_hw = 6'h0;

    // Reference model: whole architectural words plus the few hidden bits
    logic [31:0] m_status, m_cause_sw, m_count, m_compare, m_epc, m_bva;
    logic        m_ti, m_ir;
    logic [5:0]  m_hw;
    int          m_phase;

    function automatic logic [31:0] m_cause();
        return m_cause_sw | {1'b0, m_ti, 14'b0, m_hw[5] | m_ti, m_hw[4:0], 10'b0};
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd8:  return m_bva;
            5'd9:  return m_count;
            5'd11: return m_compare;
            5'd12: return m_status;
            5'd13: return m_cause();
            5'd14: return m_epc;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        m_status = 32'h0040_0000; m_cause_sw = 0; m_count = 0; m_compare = 0;
        m_epc = 0; m_bva = 0; m_ti = 0; m_ir = 0; m_hw = 0; m_phase = 0;
    endtask

    task automatic model_update(input stim_t s);
        logic [31:0] n_status, n_cause_sw, n_count, n_compare, n_epc, n_bva, cv;
        logic n_ti;
        int n_phase;
        n_status = m_status; n_cause_sw = m_cause_sw; n_count = m_count;
        n_compare = m_compare; n_epc = m_epc; n_bva = m_bva; n_phase = m_phase;
        n_ti = m_ti || (m_count == m_compare);
        if (s.wr_en) begin
            case (s.wr_addr)
                5'd11: begin n_compare = s.wr_data; n_ti = 0; end
                5'd12: n_status = (s.wr_data & 32'h0000_FF03) | 32'h0040_0000;
                5'd13: n_cause_sw = (m_cause_sw & ~32'h300) | (s.wr_data & 32'h300);
                5'd14: n_epc = s.wr_data;
                default: ;
            endcase
        end
        if (s.wr_en && s.wr_addr == 5'd9) begin
            n_count = s.wr_data; n_phase = 0;
        end else begin
            n_phase = (m_phase + 1) % DIV;
            if (n_phase == 0) n_count = m_count + 1;
        end
        if (s.eret && !s.exc) n_status[1] = 1'b0;
        if (s.exc) begin
            n_status[1] = 1'b1;
            n_cause_sw[6:2] = s.code;
            if (!m_status[1]) begin
                n_epc = s.bd ? s.pc - 32'd4 : s.pc;
                n_cause_sw[31] = s.bd;
            end
            if (s.bwe) n_bva = s.bva;
        end
        cv = m_cause();
        m_ir = m_status[0] && !m_status[1] && ((cv[15:8] & m_status[15:8]) != 8'h0);
        m_status = n_status; m_cause_sw = n_cause_sw; m_count = n_count;
        m_compare = n_compare; m_epc = n_epc; m_bva = n_bva; m_ti = n_ti;
        m_phase = n_phase; m_hw = s.hw;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    endtask

    task automatic step(input stim_t s);
        exp_t e;
        @(negedge clk);
        rst_n = ~s.rst;
        bus.rd_addr = s.rd_addr; bus.wr_en = s.wr_en; bus.wr_addr = s.wr_addr;
        bus.wr_data = s.wr_data; bus.exc_valid = s.exc; bus.exc_code = s.code;
        bus.exc_pc = s.pc; bus.exc_bd = s.bd; bus.exc_badvaddr_we = s.bwe;
        bus.exc_badvaddr = s.bva; bus.eret = s.eret; bus.hw_int = s.hw;
        if (s.rst) model_reset();
        e.rd = m_read(s.rd_addr); e.st = m_status; e.ca = m_cause(); e.epc = m_epc; e.ir = m_ir;
        expq.push_back(e);
        if (!s.rst) model_update(s);
    endtask

    function automatic stim_t idle(input logic [4:0] rd);
        stim_t s;
        s.rst = 0; s.rd_addr = rd; s.wr_en = 0; s.wr_addr = 0; s.wr_data = 0;
        s.exc = 0; s.code = 0; s.pc = 0; s.bd = 0; s.bwe = 0; s.bva = 0;
        s.eret = 0; s.hw = cur_hw;
        return s;
    endfunction

    task automatic do_wr(input logic [4:0] a, input logic [31:0] d);
        stim_t s;
        s = idle(a); s.wr_en = 1; s.wr_addr = a; s.wr_data = d;
        step(s);
    endtask

    task automatic do_exc(input logic [4:0] code, input logic [31:0] pc, input bit bd,
                          input bit bwe, input logic [31:0] bva, input bit er);
        stim_t s;
        s = idle(8); s.exc = 1; s.code = code; s.pc = pc; s.bd = bd;
        s.bwe = bwe; s.bva = bva; s.eret = er;
        step(s);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk("rd_data", bus.rd_data, e.rd);
                chk("status_out", bus.status_out, e.st);
                chk("cause_out", bus.cause_out, e.ca);
                chk("epc_out", bus.epc_out, e.epc);
                chk("int_req", {31'b0, bus.int_req}, {31'b0, e.ir});
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_chk);
        $fatal(1);
    end

    initial begin : stimulus
        stim_t s;
        logic [4:0] waddrs [8];
        waddrs = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd0, 5'd15};
        rst_n = 1'b0;
        model_reset();

        s = idle(12); s.rst = 1; step(s);
        #2 chk("reset_status_read", bus.rd_data, 32'h0040_0000);
        s = idle(5); s.rst = 1; step(s);
        #2 chk("reset_unimpl_read", bus.rd_data, 32'h0);
        chk("reset_int_req", {31'b0, bus.int_req}, 32'h0);

        step(idle(12));
        do_wr(12, 32'h0000_8001);
        do_wr(11, 32'd5);
        repeat (16) step(idle(9));
        #2 chk("timer_ti", {31'b0, bus.cause_out[30]}, 32'h1);
        chk("timer_int_req", {31'b0, bus.int_req}, 32'h1);
        do_wr(11, 32'h0000_1000);
        step(idle(13));
        #2 chk("ti_cleared", {31'b0, bus.cause_out[30]}, 32'h0);

        do_exc(5'd4, 32'hBFC0_0100, 1, 1, 32'h0000_1003, 0);
        step(idle(8));
        #2 chk("exc_epc_bd", bus.epc_out, 32'hBFC0_00FC);
        chk("exc_cause_bd", {31'b0, bus.cause_out[31]}, 32'h1);
        chk("exc_code", {27'b0, bus.cause_out[6:2]}, 32'd4);
        chk("exc_exl", {31'b0, bus.status_out[1]}, 32'h1);
        chk("exc_badvaddr", bus.rd_data, 32'h0000_1003);
        do_exc(5'd8, 32'h8000_0000, 0, 0, 32'h0, 0);
        step(idle(14));
        #2 chk("nested_epc", bus.epc_out, 32'hBFC0_00FC);

        s = idle(12); s.eret = 1; step(s);
        step(idle(12));
        #2 chk("eret_exl", {31'b0, bus.status_out[1]}, 32'h0);
        do_exc(5'd0, 32'h8000_0180, 0, 0, 32'h0, 1);
        step(idle(12));
        #2 chk("exc_over_eret", {31'b0, bus.status_out[1]}, 32'h1);
        s = idle(12); s.eret = 1; step(s);
        step(idle(12));
        #2 chk("eret_alone", {31'b0, bus.status_out[1]}, 32'h0);

        do_wr(9, 32'hFFFF_FFFF);
        step(idle(9));
        step(idle(9));
        step(idle(9));
        #2 chk("count_wrap", bus.rd_data, 32'h0);
        do_wr(13, 32'hFFFF_FFFF);
        step(idle(13));
        #2 chk("cause_sw_ip", {30'b0, bus.cause_out[9:8]}, 32'h3);
        chk("cause_ro_bits", bus.cause_out & 32'h3FFF_0083, 32'h0);

        do_wr(12, 32'h0000_1001);
        cur_hw = 6'h04;
        step(idle(13));
        step(idle(13));
        step(idle(13));
        #2 chk("hw_int_req", {31'b0, bus.int_req}, 32'h1);
        do_exc(5'd1, 32'h8000_0200, 0, 0, 32'h0, 0);
        step(idle(13));
        step(idle(13));
        #2 chk("exl_masks_int", {31'b0, bus.int_req}, 32'h0);

        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 49) == 0) cur_hw = 6'($urandom);
            s = idle(5'($urandom));
            if ($urandom_range(0, 2) == 0) s.rd_addr = waddrs[$urandom_range(0, 5)];
            s.rst = ($urandom_range(0, 199) == 0);
            s.wr_en = ($urandom_range(0, 9) < 3);
            s.wr_addr = waddrs[$urandom_range(0, 7)];
            s.wr_data = ($urandom_range(0, 3) == 0) ? m_count + 32'($urandom_range(0, 7)) : $urandom;
            s.exc = ($urandom_range(0, 9) == 0);
            s.code = 5'($urandom);
            s.pc = $urandom;
            s.bd = 1'($urandom);
            s.bwe = 1'($urandom);
            s.bva = $urandom;
            s.eret = ($urandom_range(0, 9) == 0);
            step(s);
        end

        @(negedge clk);
        #3;
        chk("scoreboard_drained", 32'(expq.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
